// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader placed in front of the rv32i core. It takes a byte
// stream, rebuilds little-endian 32-bit instruction words and writes them into
// instruction memory at consecutive word addresses starting at BASE_ADDR. The
// core is held (o_core_run = 0) until the whole image has been written and the
// trailing XOR checksum byte matches.
//
// Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes (LSB of each word
// first), then one checksum byte = XOR of all data bytes.
//
// Handshake: a byte moves on a rising edge where i_in_valid && o_in_ready.
// The source may hold i_in_valid low for any number of cycles; the loader
// simply waits. o_in_ready depends only on state (never on i_in_valid), is
// high in every accepting state and low once the loader is terminal.
//
// Ports:
//   i_clk           clock, all logic on its rising edge
//   i_rst_n         synchronous active-low reset
//   i_in_valid      source presents a byte
//   o_in_ready      loader accepts a byte this cycle
//   i_in_data       stream byte
//   o_mem_we        one-cycle write strobe per assembled word
//   o_mem_addr      word-aligned byte address of the word being written
//   o_mem_wdata     assembled instruction word
//   o_core_run      core release (0 keeps the core in reset)
//   o_busy          length byte taken, not yet finished (RUN/ERR)
//   o_done          image loaded and checksum matched
//   o_error         oversize length or checksum mismatch
//   o_words_loaded  words written since reset
//   o_dbg_state     current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned         ADDR_W    = 16,
  parameter int unsigned         DEPTH     = 1024,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [7:0]        i_in_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_run,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_words_loaded,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t              r_state;
  logic [15:0]         r_len;
  logic [15:0]         r_word_idx;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic [7:0]          r_csum;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_core_run;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [15:0]         r_words_loaded;

  logic                w_accept;
  logic [15:0]         w_len_full;
  logic [31:0]         w_addr_sum;
  logic                w_last_word;
  logic                w_oversize;

  assign w_accept    = i_in_valid && r_in_ready;
  // Full length as it will be once the high byte lands this cycle.
  assign w_len_full  = {i_in_data, r_len[7:0]};
  assign w_oversize  = 32'(w_len_full) > DEPTH;
  // Address is computed wide and then truncated, so it wraps modulo 2^ADDR_W.
  assign w_addr_sum  = 32'(BASE_ADDR) + {14'd0, r_word_idx, 2'b00};
  // N never exceeds DEPTH here, so the +1 cannot overflow 16 bits.
  assign w_last_word = (r_word_idx + 16'd1) == r_len;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_LEN_LO;
      r_len          <= 16'd0;
      r_word_idx     <= 16'd0;
      r_byte_cnt     <= 2'd0;
      r_shift        <= 24'd0;
      r_csum         <= 8'd0;
      r_in_ready     <= 1'b1;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_wdata    <= 32'd0;
      r_core_run     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 16'd0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold afterwards.
      r_mem_we <= 1'b0;

      if (w_accept) begin
        case (r_state)
          S_LEN_LO: begin
            r_len[7:0] <= i_in_data;
            r_busy     <= 1'b1;
            r_state    <= S_LEN_HI;
          end

          S_LEN_HI: begin
            r_len[15:8] <= i_in_data;
            if (w_oversize) begin
              r_state    <= S_ERR;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else if (w_len_full == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA;
            end
          end

          S_DATA: begin
            r_csum     <= r_csum ^ i_in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_shift[7:0]   <= i_in_data;
              2'd1: r_shift[15:8]  <= i_in_data;
              2'd2: r_shift[23:16] <= i_in_data;
              2'd3: begin
                // Fourth byte completes the word: register the write now so
                // the strobe, address and data all appear next cycle.
                r_mem_we       <= 1'b1;
                r_mem_addr     <= w_addr_sum[ADDR_W-1:0];
                r_mem_wdata    <= {i_in_data, r_shift};
                r_words_loaded <= r_words_loaded + 16'd1;
                r_word_idx     <= r_word_idx + 16'd1;
                if (w_last_word) begin
                  r_state <= S_CHECK;
                end
              end
              default: ;
            endcase
          end

          S_CHECK: begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            if (i_in_data == r_csum) begin
              r_state    <= S_RUN;
              r_core_run <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end

          // S_RUN / S_ERR are terminal; only reset leaves them.
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_core_run     = r_core_run;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words_loaded;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Bench for imem_loader. A frame-level reference model turns each byte frame
// into the list of expected memory writes (pushed onto exp_q) plus the
// expected pass/fail outcome. A monitor pops exp_q on every o_mem_we.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 1024;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam int          W      = 48;  // {addr[15:0], data[31:0]}

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;
  logic [2:0]        dbg_state;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_core_run     (core_run),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded),
    .o_dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},     in_ready,     1);
    check({tag, "_mem_we"},       mem_we,       0);
    check({tag, "_mem_addr"},     mem_addr,     BASE);
    check({tag, "_mem_wdata"},    mem_wdata,    0);
    check({tag, "_core_run"},     core_run,     0);
    check({tag, "_busy"},         busy,         0);
    check({tag, "_done"},         done,         0);
    check({tag, "_error"},        error,        0);
    check({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  // ---------------------------------------------------------------- monitor
  logic         prev_we = 1'b0;
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (prev_we) check("we_pulse_width", mem_we, 0);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_addr,  mon_e[47:32]);
          check("wr_data", mem_wdata, mon_e[31:0]);
        end
      end
      prev_we = mem_we;
    end
  end

  // ---------------------------------------------------------------- driver
  // Returns #1 after the edge that took the byte; acc = in_ready at that edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit acc);
    int g = 0;
    while (g < 16 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b1;
    in_data  = b;
    acc      = in_ready;
    @(posedge clk);
    #1;
  endtask

  // Reference model + drive + end-of-frame checks for one complete frame.
  task automatic run_frame(input string tag, input logic [7:0] fr[$], input int gap_pct);
    int   n;
    int   nsend;
    bit   over;
    bit   exp_ok;
    int   n_words;
    bit   acc;
    logic [7:0] x;
    n    = int'({fr[1], fr[0]});
    over = (n > int'(DEPTH));
    if (over) begin
      exp_ok  = 1'b0;
      n_words = 0;
      nsend   = 2;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({BASE + 16'(4 * i),
                         fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
      end
      for (int i = 2; i < 2 + 4 * n; i++) x ^= fr[i];
      exp_ok  = (fr[2+4*n] == x);
      n_words = n;
      nsend   = 4 * n + 3;
    end

    for (int k = 0; k < nsend; k++) begin
      send_byte(fr[k], gap_pct, acc);
      check({tag, "_accept"}, acc, 1);
      if (k == 0) check({tag, "_busy_rise"}, busy, 1);
      if (!over && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3) begin
        check({tag, "_we_latency"}, mem_we, 1);
        check({tag, "_words_inc"}, words_loaded, 48'((k - 2) / 4 + 1));
      end
    end
    in_valid = 1'b0;

    // Cycle right after the final accepted byte.
    check({tag, "_done"},         done,         exp_ok);
    check({tag, "_error"},        error,        !exp_ok);
    check({tag, "_core_run"},     core_run,     exp_ok);
    check({tag, "_in_ready"},     in_ready,     0);
    check({tag, "_busy_fall"},    busy,         0);
    check({tag, "_words_loaded"}, words_loaded, 48'(n_words));
    check({tag, "_pending_wr"},   exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] img[$];
    logic [7:0] fr[$];
    bit         acc;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    do_reset();
    check_reset_state("reset");

    // Two-word image; XOR of its eight data bytes is 0xB0.
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    fr = img; fr.push_back(8'hB0);
    run_frame("two_word", fr, 0);

    do_reset();
    fr = img; fr.push_back(8'hB1);
    run_frame("two_word_badcs", fr, 0);

    do_reset();
    fr = img; fr.push_back(8'h80);
    run_frame("two_word_cs80", fr, 0);

    do_reset();
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame("zero_len", fr, 0);

    do_reset();
    fr = '{8'h00, 8'h00, 8'h01};
    run_frame("zero_len_badcs", fr, 0);

    // Oversize length then 100 cycles of offered bytes that must be refused.
    do_reset();
    fr = '{8'h01, 8'h04};
    run_frame("oversize", fr, 0);
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
      check("oversize_hold_ready", in_ready, 0);
      check("oversize_hold_error", error, 1);
    end
    in_valid = 1'b0;

    do_reset();
    fr = img; fr.push_back(8'hB0);
    run_frame("backpressure", fr, 50);

    // Reset after two data bytes, then a fresh one-word frame.
    do_reset();
    send_byte(8'h02, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h13, 0, acc);
    send_byte(8'h05, 0, acc);
    do_reset();
    check_reset_state("reset_mid");
    fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_frame("after_reset", fr, 0);

    // Largest legal image: exactly DEPTH words.
    do_reset();
    begin
      logic [7:0] x;
      logic [7:0] b;
      fr.delete();
      fr.push_back(8'(DEPTH));
      fr.push_back(8'(DEPTH >> 8));
      x = 8'h00;
      for (int j = 0; j < 4 * int'(DEPTH); j++) begin
        b = 8'($urandom);
        fr.push_back(b);
        x ^= b;
      end
      fr.push_back(x);
      run_frame("depth_max", fr, 0);
    end

    // Randomised frames: lengths, data, gaps, corrupted checksums, oversize.
    for (int it = 0; it < 24; it++) begin
      int         n;
      logic [7:0] x;
      logic [7:0] b;
      do_reset();
      fr.delete();
      if ($urandom_range(7) == 0) begin
        n = int'($urandom_range(1025, 65535));
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
      end else begin
        n = int'($urandom_range(0, 8));
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        x = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          b = 8'($urandom);
          fr.push_back(b);
          x ^= b;
        end
        if ($urandom_range(3) == 0) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      run_frame("rand", fr, int'($urandom_range(0, 60)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
